time_set_unit: RTL
==================

Name: time_set_unit

Overview:
- Consumer end of the clock's setting-mode control: responds to the `set_time_en` level issued by the mode control FSM.
- While `set_time_en` is high, the user edits a shadow copy of hour/minute/second with debounced buttons.
- When `set_time_en` falls, it emits a one-cycle load strobe plus the new time to the timekeeping counter.
- Sits between the mode control FSM, the button debouncers and the time counter / display blink logic.

Parameters:
- HOUR_MAX, 23, largest hour value; hours wrap HOUR_MAX <-> 0.
- REPEAT_DELAY, 500, cycles an inc/dec button must be held before auto-repeat starts (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 100, cycles between auto-repeat steps (used only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- set_time_en  in  1  level from the mode control FSM; high = time-setting mode
- field_btn  in  1  debounced level; rising edge advances the edited field
- inc_btn  in  1  debounced level; rising edge increments the current field
- dec_btn  in  1  debounced level; rising edge decrements the current field
- cur_hour  in  5  live hour from the time counter
- cur_min  in  6  live minute
- cur_sec  in  6  live second
- set_hour  out  5  shadow hour
- set_min  out  6  shadow minute
- set_sec  out  6  shadow second
- load_time  out  1  one-cycle strobe; time counter loads set_* when high
- blink_field  out  3  one-hot field being edited: [2]=hour, [1]=min, [0]=sec; 0 when not editing
- editing  out  1  high in any EDIT state

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - state = IDLE
  - set_hour/set_min/set_sec = 0
  - load_time = 0
  - blink_field = 0
  - editing = 0
  - button history registers = 0
- Edge detection: a registered copy of each button is kept. An edge is btn & ~btn_q. A button already high when a field is entered does not fire until it is released and pressed again.
- States: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE:
  - set_time_en sampled high -> capture cur_* into set_* on the same edge and go to EDIT_HOUR.
  - Shadow values are visible the next cycle.
- EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> EDIT_HOUR, advancing on each field_btn edge.
- Any EDIT state with set_time_en sampled low -> COMMIT (this takes priority over all button events in that cycle).
- COMMIT:
  - load_time = 1 for exactly one cycle; set_* are held stable.
  - Next state is IDLE unconditionally, even if set_time_en is already high again.
- Outputs blink_field, editing and load_time are decoded from registered state only (Moore). An edit event sampled at edge n is visible on set_* after edge n.
- Arithmetic wrap:
  - hour: inc wraps HOUR_MAX -> 0; dec wraps 0 -> HOUR_MAX.
  - min/sec: inc wraps 59 -> 0; dec wraps 0 -> 59.
  - Captured out-of-range values (hour > HOUR_MAX, min/sec > 59) are clamped to 0 on capture.
- Simultaneous events in one cycle:
  - field edge together with inc/dec edge: field advances; inc/dec is ignored.
  - inc edge together with dec edge: both are ignored.
- Values in IDLE: set_* hold their last value. The time counter must only use set_* when load_time is high.
- Reset mid-edit: returns to IDLE with no load_time pulse, and the edits are discarded.

Optional Feature:
- Macro: AUTO_REPEAT_EN
- Defined:
  - A per-button hold counter for inc_btn and dec_btn.
  - The initial edge steps once. If the button is still held for REPEAT_DELAY cycles, one extra step is issued, then one more every REPEAT_PERIOD cycles until release.
  - The counter clears on release, on a field change, or on leaving the EDIT states.
  - inc and dec held together produce no steps.
- Undefined: edge-only stepping; no hold counters are synthesized.

Decomposition:
- Shared package clock_pkg:
  - state enum ts_state_t {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT}
  - constants HOUR_W=5, MIN_W=6, SEC_W=6, MIN_SEC_MAX=59
  - field one-hot localparams FLD_HOUR=3'b100, FLD_MIN=3'b010, FLD_SEC=3'b001
- One sub-module, btn_step_gen: edge detector plus the optional auto-repeat counter. It is instantiated twice (inc, dec) and outputs a one-cycle step pulse. field_btn uses its own plain edge detector.

Test Plan:
- Enter at 12:34:56 -> set_*=12/34/56 one cycle after set_time_en rises; blink_field=3'b100; editing=1.
- In EDIT_HOUR at 23, one inc edge -> set_hour=0. Then field edge, then dec at min 0 -> set_min=59, blink_field=3'b010.
- Drop set_time_en in EDIT_SEC with sec=7 -> exactly one cycle of load_time=1 with set_*=h/m/7, then IDLE, blink_field=0.
- field and inc edges in the same cycle at hour 5 -> blink_field moves to min and set_hour stays 5. inc+dec together at min 30 -> stays 30.
- Assert rst_n=0 for one cycle mid-edit -> next cycle IDLE, set_*=0, no load_time pulse ever.
- With AUTO_REPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2: hold inc for 10 cycles from min 0 -> set_min=4 (edge, then +1 at cycles 4, 6, 8). Without the macro -> set_min=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock time-setting path.
// Holds the setting-FSM state encoding, field widths, the one-hot field
// codes used for display blinking, and the wrap/clamp arithmetic shared by
// every editable field.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EDIT_HOUR = 3'd1,
    EDIT_MIN  = 3'd2,
    EDIT_SEC  = 3'd3,
    COMMIT    = 3'd4
  } ts_state_t;

  localparam int HOUR_W      = 5;
  localparam int MIN_W       = 6;
  localparam int SEC_W       = 6;
  localparam int MIN_SEC_MAX = 59;

  localparam logic [2:0] FLD_HOUR = 3'b100;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_SEC  = 3'b001;
  localparam logic [2:0] FLD_NONE = 3'b000;

  // Step a field value by one in either direction, wrapping at 0 and max_v.
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] max_v,
                                           input logic       up);
    logic [5:0] res;
    if (up) begin
      if (val >= max_v) begin
        res = 6'd0;
      end else begin
        res = val + 6'd1;
      end
    end else begin
      if (val == 6'd0) begin
        res = max_v;
      end else begin
        res = val - 6'd1;
      end
    end
    return res;
  endfunction

  // Values outside the legal range of a field are replaced by zero.
  function automatic logic [5:0] clamp_cap(input logic [5:0] val,
                                           input logic [5:0] max_v);
    logic [5:0] res;
    if (val > max_v) begin
      res = 6'd0;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Field rotation order while editing: hour -> min -> sec -> hour.
  function automatic ts_state_t next_field(input ts_state_t s);
    ts_state_t res;
    case (s)
      EDIT_HOUR: res = EDIT_MIN;
      EDIT_MIN:  res = EDIT_SEC;
      EDIT_SEC:  res = EDIT_HOUR;
      default:   res = EDIT_HOUR;
    endcase
    return res;
  endfunction

  // One-hot blink code for a state; zero outside the edit states.
  function automatic logic [2:0] field_onehot(input ts_state_t s);
    logic [2:0] res;
    case (s)
      EDIT_HOUR: res = FLD_HOUR;
      EDIT_MIN:  res = FLD_MIN;
      EDIT_SEC:  res = FLD_SEC;
      default:   res = FLD_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_step_gen.sv
// Turns a debounced button level into one-cycle step pulses.
// Default build: a single pulse on each rising edge.
// With AUTO_REPEAT_EN defined: after REPEAT_DELAY held cycles an extra
// step is issued, then one every REPEAT_PERIOD cycles until release.
// clear_i cancels any pending repeat and also masks the pulse, because a
// cleared button has no field to act on in that cycle.
module btn_step_gen #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic clear_i,
  output logic step_o
);

  logic btn_q;
  logic btn_d;
  logic edge_s;

  assign edge_s = btn_i & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             armed_q;
  logic             armed_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic             rpt_s;

  // Hold timer: armed by an edge, counts down while held, reloads on each repeat.
  always_comb begin
    btn_d   = btn_i;
    armed_d = armed_q;
    timer_d = timer_q;
    rpt_s   = 1'b0;
    if (clear_i) begin
      armed_d = 1'b0;
      timer_d = CNT_ZERO;
    end else if (edge_s) begin
      armed_d = 1'b1;
      timer_d = DELAY_LD;
    end else if (armed_q && btn_i) begin
      if (timer_q == CNT_ZERO) begin
        rpt_s   = 1'b1;
        timer_d = PERIOD_LD;
      end else begin
        timer_d = timer_q - CNT_ONE;
      end
    end else begin
      armed_d = 1'b0;
      timer_d = CNT_ZERO;
    end
  end

  assign step_o = (edge_s | rpt_s) & ~clear_i;

  // Button history and hold timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      timer_q <= CNT_ZERO;
    end else begin
      btn_q   <= btn_d;
      armed_q <= armed_d;
      timer_q <= timer_d;
    end
  end
`else
  // Edge-only stepping: the history register is the whole state.
  always_comb begin
    btn_d = btn_i;
  end

  assign step_o = edge_s & ~clear_i;

  // Button history register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end
`endif

endmodule

// File: rtl/time_set_unit.sv
// Time-setting unit: while set_time_en is high the user edits a shadow
// hour/minute/second with field/inc/dec buttons; when set_time_en falls a
// one-cycle load_time strobe hands the shadow time to the time counter.
// Optional feature macro: AUTO_REPEAT_EN (held inc/dec auto-repeat).
module time_set_unit
  import clock_pkg::*;
#(
  parameter int HOUR_MAX      = 23,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_time_en,
  input  logic              field_btn,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic [SEC_W-1:0]  set_sec,
  output logic              load_time,
  output logic [2:0]        blink_field,
  output logic              editing
);

  localparam logic [5:0] HOUR_MAX_6 = 6'(HOUR_MAX);
  localparam logic [5:0] MS_MAX_6   = 6'(MIN_SEC_MAX);

  ts_state_t         state_q;
  ts_state_t         state_d;
  logic [HOUR_W-1:0] set_hour_q;
  logic [HOUR_W-1:0] set_hour_d;
  logic [MIN_W-1:0]  set_min_q;
  logic [MIN_W-1:0]  set_min_d;
  logic [SEC_W-1:0]  set_sec_q;
  logic [SEC_W-1:0]  set_sec_d;
  logic              load_time_q;
  logic              load_time_d;
  logic [2:0]        blink_field_q;
  logic [2:0]        blink_field_d;
  logic              editing_q;
  logic              editing_d;
  logic              field_q;
  logic              field_d;

  logic field_edge_s;
  logic edit_active_s;
  logic step_clr_s;
  logic inc_step_s;
  logic dec_step_s;
  logic inc_ok_s;
  logic dec_ok_s;

  assign field_edge_s  = field_btn & ~field_q;
  assign edit_active_s = set_time_en &
                         ((state_q == EDIT_HOUR) | (state_q == EDIT_MIN) | (state_q == EDIT_SEC));

`ifdef AUTO_REPEAT_EN
  // Holding inc and dec together must never step, so it also cancels repeats.
  assign step_clr_s = ~edit_active_s | field_edge_s | (inc_btn & dec_btn);
  assign inc_ok_s   = inc_step_s & ~dec_btn;
  assign dec_ok_s   = dec_step_s & ~inc_btn;
`else
  assign step_clr_s = ~edit_active_s | field_edge_s;
  assign inc_ok_s   = inc_step_s & ~dec_step_s;
  assign dec_ok_s   = dec_step_s & ~inc_step_s;
`endif

  btn_step_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_inc_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (inc_btn),
    .clear_i (step_clr_s),
    .step_o  (inc_step_s)
  );

  btn_step_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_dec_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (dec_btn),
    .clear_i (step_clr_s),
    .step_o  (dec_step_s)
  );

  // Next state, shadow time update and Moore output decode of the next state.
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    field_d    = field_btn;

    case (state_q)
      IDLE: begin
        if (set_time_en) begin
          set_hour_d = HOUR_W'(clamp_cap({1'b0, cur_hour}, HOUR_MAX_6));
          set_min_d  = MIN_W'(clamp_cap(cur_min, MS_MAX_6));
          set_sec_d  = SEC_W'(clamp_cap(cur_sec, MS_MAX_6));
          state_d    = EDIT_HOUR;
        end else begin
          state_d = IDLE;
        end
      end
      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        if (!set_time_en) begin
          state_d = COMMIT;
        end else if (field_edge_s) begin
          state_d = next_field(state_q);
        end else if (inc_ok_s || dec_ok_s) begin
          case (state_q)
            EDIT_HOUR: set_hour_d = HOUR_W'(wrap_step({1'b0, set_hour_q}, HOUR_MAX_6, inc_ok_s));
            EDIT_MIN:  set_min_d  = MIN_W'(wrap_step(set_min_q, MS_MAX_6, inc_ok_s));
            EDIT_SEC:  set_sec_d  = SEC_W'(wrap_step(set_sec_q, MS_MAX_6, inc_ok_s));
            default:   set_hour_d = set_hour_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_time_d   = (state_d == COMMIT);
    blink_field_d = field_onehot(state_d);
    editing_d     = (blink_field_d != FLD_NONE);
  end

  // State, shadow time, field-button history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      set_hour_q    <= {HOUR_W{1'b0}};
      set_min_q     <= {MIN_W{1'b0}};
      set_sec_q     <= {SEC_W{1'b0}};
      load_time_q   <= 1'b0;
      blink_field_q <= FLD_NONE;
      editing_q     <= 1'b0;
      field_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_hour_q    <= set_hour_d;
      set_min_q     <= set_min_d;
      set_sec_q     <= set_sec_d;
      load_time_q   <= load_time_d;
      blink_field_q <= blink_field_d;
      editing_q     <= editing_d;
      field_q       <= field_d;
    end
  end

  assign set_hour    = set_hour_q;
  assign set_min     = set_min_q;
  assign set_sec     = set_sec_q;
  assign load_time   = load_time_q;
  assign blink_field = blink_field_q;
  assign editing     = editing_q;

endmodule
